// File: rtl/systolic_mm_engine_if.sv
// Job, operand and result handshake bundle for the systolic matrix-multiply engine.
// master = job/operand producer and result consumer, slave = engine.
interface systolic_mm_engine_if #(
   parameter int N         = 4,
   parameter int BIT_WIDTH = 16,
   parameter int K_MAX     = 64
);
   localparam int KW = $clog2(K_MAX + 1);
   localparam int RW = $clog2(N);

   logic                   start;
   logic                   acc_mode;
   logic [KW-1:0]          k_len;
   logic                   busy;
   logic                   in_valid;
   logic                   in_ready;
   logic [N*BIT_WIDTH-1:0] a_col;
   logic [N*BIT_WIDTH-1:0] b_row;
   logic                   out_valid;
   logic                   out_ready;
   logic [N*BIT_WIDTH-1:0] out_row;
   logic [RW-1:0]          out_row_idx;
   logic                   done;

   modport master (
      output start, acc_mode, k_len, in_valid, a_col, b_row, out_ready,
      input  busy, in_ready, out_valid, out_row, out_row_idx, done
   );

   modport slave (
      input  start, acc_mode, k_len, in_valid, a_col, b_row, out_ready,
      output busy, in_ready, out_valid, out_row, out_row_idx, done
   );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary N x N systolic array computing C = A*B in signed fixed point.
// A streams east, B streams south; each PE keeps one C element in a wide accumulator.
module systolic_mm_pe #(
   parameter int BW = 16,
   parameter int AW = 39
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 adv,
   input  logic                 clr,
   input  logic signed [BW-1:0] a_i,
   input  logic signed [BW-1:0] b_i,
   output logic signed [BW-1:0] a_o,
   output logic signed [BW-1:0] b_o,
   output logic signed [AW-1:0] acc_o
);
   logic signed [2*BW-1:0] prod;
   logic signed [BW-1:0]   a_q, b_q;
   logic signed [AW-1:0]   acc_q;

   assign prod = a_i * b_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else begin
         if (adv) begin
            a_q <= a_i;
            b_q <= b_i;
         end
         if (clr)      acc_q <= '0;
         else if (adv) acc_q <= acc_q + {{(AW-2*BW){prod[2*BW-1]}}, prod};
      end
   end

   assign a_o   = a_q;
   assign b_o   = b_q;
   assign acc_o = acc_q;
endmodule

module systolic_mm_engine #(
   parameter int N          = 4,
   parameter int BIT_WIDTH  = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int K_MAX      = 64
) (
   input logic             clk,
   input logic             rst_n,
   systolic_mm_engine_if.slave mm
);
   localparam int BW = BIT_WIDTH;
   localparam int KW = $clog2(K_MAX + 1);
   localparam int AW = 2*BW + KW;
   localparam int RW = $clog2(N);
   localparam int FW = $clog2(2*N);
   localparam logic signed [AW-1:0] SMAX = {{(AW-BW+1){1'b0}}, {(BW-1){1'b1}}};
   localparam logic signed [AW-1:0] SMIN = {{(AW-BW+1){1'b1}}, {(BW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, FEED, FLUSH, DRAIN, DONE} state_e;

   state_e        st_q;
   logic [KW-1:0] k_q, cnt_q;
   logic [FW-1:0] fcnt_q;
   logic [RW-1:0] row_q;
   logic          busy_q, in_ready_q, out_valid_q, done_q;
   logic          adv, clr;

   logic signed [BW-1:0]   a_w [N][N];
   logic signed [BW-1:0]   b_w [N][N];
   logic signed [AW-1:0]   acc_w [N][N];
   logic [N-1:0][BW-1:0]   a_unused, b_unused;
   logic [N*BW-1:0]        row_w;

   // Stalled input beats freeze the whole array, so skew alignment survives gaps.
   assign adv = (st_q == FEED && mm.in_valid) || st_q == FLUSH;
   assign clr = st_q == IDLE && mm.start && !mm.acc_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= IDLE;
         k_q         <= '0;
         cnt_q       <= '0;
         fcnt_q      <= '0;
         row_q       <= '0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (st_q)
            IDLE: if (mm.start) begin
               k_q    <= mm.k_len;
               cnt_q  <= '0;
               fcnt_q <= '0;
               busy_q <= 1'b1;
               if (mm.k_len != '0) begin
                  st_q       <= FEED;
                  in_ready_q <= 1'b1;
               end else begin
                  st_q <= FLUSH;
               end
            end
            FEED: if (mm.in_valid) begin
               cnt_q <= cnt_q + KW'(1);
               if (cnt_q + KW'(1) == k_q) begin
                  st_q       <= FLUSH;
                  in_ready_q <= 1'b0;
               end
            end
            // 2N-1 zero-operand steps push the last beat through the far corner PE.
            FLUSH: begin
               fcnt_q <= fcnt_q + FW'(1);
               if (fcnt_q == FW'(2*N-2)) begin
                  st_q        <= DRAIN;
                  out_valid_q <= 1'b1;
                  row_q       <= '0;
               end
            end
            DRAIN: if (mm.out_ready) begin
               if (row_q == RW'(N-1)) begin
                  st_q        <= DONE;
                  out_valid_q <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  row_q <= row_q + RW'(1);
               end
            end
            DONE: begin
               st_q   <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   for (genvar l = 0; l < N; l++) begin : g_lane
      logic signed [BW-1:0] a_in, b_in;
      assign a_in = (st_q == FEED) ? mm.a_col[l*BW +: BW] : '0;
      assign b_in = (st_q == FEED) ? mm.b_row[l*BW +: BW] : '0;
      if (l == 0) begin : g_direct
         assign a_w[0][0] = a_in;
         assign b_w[0][0] = b_in;
      end else begin : g_skew
         logic [l-1:0][BW-1:0] ska_q, skb_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ska_q <= '0;
               skb_q <= '0;
            end else if (adv) begin
               for (int s = l-1; s > 0; s--) begin
                  ska_q[s] <= ska_q[s-1];
                  skb_q[s] <= skb_q[s-1];
               end
               ska_q[0] <= a_in;
               skb_q[0] <= b_in;
            end
         end
         assign a_w[l][0] = ska_q[l-1];
         assign b_w[0][l] = skb_q[l-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic signed [BW-1:0] a_nx, b_nx;
         systolic_mm_pe #(.BW(BW), .AW(AW)) u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (adv),
            .clr   (clr),
            .a_i   (a_w[i][j]),
            .b_i   (b_w[i][j]),
            .a_o   (a_nx),
            .b_o   (b_nx),
            .acc_o (acc_w[i][j])
         );
         if (j < N-1) begin : g_e
            assign a_w[i][j+1] = a_nx;
         end else begin : g_e_end
            assign a_unused[i] = a_nx;
         end
         if (i < N-1) begin : g_s
            assign b_w[i+1][j] = b_nx;
         end else begin : g_s_end
            assign b_unused[j] = b_nx;
         end
      end
   end

   function automatic logic [BW-1:0] sat(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] s;
      s = v >>> FRAC_WIDTH;
      if (s > SMAX)      sat = SMAX[BW-1:0];
      else if (s < SMIN) sat = SMIN[BW-1:0];
      else               sat = s[BW-1:0];
   endfunction

   always_comb begin
      row_w = '0;
      for (int j = 0; j < N; j++) row_w[j*BW +: BW] = sat(acc_w[row_q][j]);
   end

   assign mm.busy        = busy_q;
   assign mm.in_ready    = in_ready_q;
   assign mm.out_valid   = out_valid_q;
   assign mm.done        = done_q;
   assign mm.out_row     = out_valid_q ? row_w : '0;
   assign mm.out_row_idx = out_valid_q ? row_q : '0;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine (N=4, Q8.8) with hand-computed results.
module tb_systolic_mm_engine;
   localparam int N  = 4;
   localparam int BW = 16;
   localparam int KW = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   systolic_mm_engine_if #(.N(N), .BIT_WIDTH(BW), .K_MAX(64)) mm ();

   systolic_mm_engine #(.N(N), .BIT_WIDTH(BW), .FRAC_WIDTH(8), .K_MAX(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mm    (mm.slave)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, 64'(mm.busy), 64'd0);
      chk({tag, "_in_ready"}, 64'(mm.in_ready), 64'd0);
      chk({tag, "_out_valid"}, 64'(mm.out_valid), 64'd0);
      chk({tag, "_done"}, 64'(mm.done), 64'd0);
      chk({tag, "_out_row"}, mm.out_row, 64'd0);
      chk({tag, "_row_idx"}, 64'(mm.out_row_idx), 64'd0);
   endtask

   task automatic start_job(input logic acc, input int k);
      mm.start    = 1'b1;
      mm.acc_mode = acc;
      mm.k_len    = KW'(k);
      tick();
      mm.start = 1'b0;
   endtask

   // Identity mode drives A column t as 1.0 on lane t only.
   task automatic feed(input int k, input logic [63:0] a, input logic [63:0] b,
                       input bit ident, input bit gaps);
      int w;
      for (int t = 0; t < k; t++) begin
         if (gaps) begin
            mm.in_valid = 1'b0;
            repeat (t % 3 + 1) tick();
         end
         mm.in_valid = 1'b1;
         mm.a_col    = ident ? (64'h0100 << (16 * t)) : a;
         mm.b_row    = b;
         w = 0;
         while (!mm.in_ready && w < 20) begin
            tick();
            w++;
         end
         if (w == 20) chk("in_ready_timeout", 64'd0, 64'd1);
         tick();
      end
      mm.in_valid = 1'b0;
      mm.a_col    = '0;
      mm.b_row    = '0;
   endtask

   // n counts cycles from the one right after the last accepting edge (n=1)
   // through the first cycle that shows out_valid.
   task automatic wait_valid(output int n);
      n = 1;
      while (!mm.out_valid && n < 100) begin
         tick();
         n++;
      end
      if (!mm.out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain(input logic [63:0] exp, input int stall);
      int w;
      for (int r = 0; r < N; r++) begin
         w = 0;
         while (!mm.out_valid && w < 50) begin
            tick();
            w++;
         end
         if (w == 50) chk("drain_timeout", 64'd0, 64'd1);
         chk("row_idx", 64'(mm.out_row_idx), 64'(r));
         chk("row_data", mm.out_row, exp);
         if (r == stall) begin
            mm.out_ready = 1'b0;
            repeat (3) begin
               tick();
               chk("hold_valid", 64'(mm.out_valid), 64'd1);
               chk("hold_idx", 64'(mm.out_row_idx), 64'(r));
               chk("hold_row", mm.out_row, exp);
            end
         end
         mm.out_ready = 1'b1;
         tick();
         mm.out_ready = 1'b0;
      end
      chk("done_pulse", 64'(mm.done), 64'd1);
      chk("valid_after_drain", 64'(mm.out_valid), 64'd0);
      chk("row_zero_when_idle", mm.out_row, 64'd0);
      tick();
      chk("done_clear", 64'(mm.done), 64'd0);
      chk("busy_clear", 64'(mm.busy), 64'd0);
   endtask

   task automatic run_job(input logic acc, input int k, input logic [63:0] a,
                          input logic [63:0] b, input bit ident, input bit gaps,
                          input logic [63:0] exp, input int stall);
      int n;
      start_job(acc, k);
      chk("busy_after_start", 64'(mm.busy), 64'd1);
      chk("in_ready_after_start", 64'(mm.in_ready), (k > 0) ? 64'd1 : 64'd0);
      if (k > 0) begin
         feed(k, a, b, ident, gaps);
         wait_valid(n);
         chk("first_valid_latency", 64'(n), 64'd8);
      end
      drain(exp, stall);
   endtask

   initial begin
      mm.start     = 1'b0;
      mm.acc_mode  = 1'b0;
      mm.k_len     = '0;
      mm.in_valid  = 1'b0;
      mm.a_col     = '0;
      mm.b_row     = '0;
      mm.out_ready = 1'b0;

      #2 rst_n = 1'b0;
      tick();
      tick();
      chk_quiet("reset");
      rst_n = 1'b1;
      tick();

      // 1.0 * 2.0 summed over 4 beats = 8.0
      run_job(1'b0, 4, {4{16'h0100}}, {4{16'h0200}}, 1'b0, 1'b0, {4{16'h0800}}, -1);
      run_job(1'b1, 4, {4{16'h0100}}, {4{16'h0200}}, 1'b0, 1'b0, {4{16'h1000}}, -1);
      run_job(1'b0, 0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0, -1);
      run_job(1'b0, 4, {4{16'h7FFF}}, {4{16'h7FFF}}, 1'b0, 1'b0, {4{16'h7FFF}}, -1);
      run_job(1'b0, 4, {4{16'h7FFF}}, {4{16'h8000}}, 1'b0, 1'b0, {4{16'h8000}}, -1);
      // A = I, every B row = [1,2,3,4] -> C = B, beats separated by 1-3 idle cycles
      run_job(1'b0, 4, 64'd0, 64'h0400_0300_0200_0100, 1'b1, 1'b1,
              64'h0400_0300_0200_0100, -1);
      run_job(1'b0, 4, {4{16'h0100}}, {4{16'h0200}}, 1'b0, 1'b0, {4{16'h0800}}, 1);

      // Abort a job during FLUSH.
      start_job(1'b0, 4);
      feed(4, {4{16'h0100}}, {4{16'h0200}}, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_quiet("midflush_reset");
      tick();
      rst_n = 1'b1;
      tick();
      // acc_mode=1 here: a correct 8.0 shows reset cleared the aborted partial sums.
      run_job(1'b1, 4, {4{16'h0100}}, {4{16'h0200}}, 1'b0, 1'b0, {4{16'h0800}}, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
